// File: rtl/mor1kx_tlb_reload_walker_port_if.sv
// MMU reload handshakes (DMMU/IMMU req/addr/ack/data) plus the walker's Wishbone
// classic read master, bundled for the TLB reload walker port.
interface mor1kx_tlb_reload_walker_port_if #(
  parameter int OPTION_OPERAND_WIDTH = 32
);
  logic                            dmmu_req_i;
  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i;
  logic                            dmmu_ack_o;
  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o;
  logic                            immu_req_i;
  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i;
  logic                            immu_ack_o;
  logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o;
  logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o;
  logic                            wbm_cyc_o;
  logic                            wbm_stb_o;
  logic                            wbm_we_o;
  logic [3:0]                      wbm_sel_o;
  logic                            wbm_ack_i;
  logic                            wbm_err_i;
  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i;
  logic                            busy_o;
  logic                            bus_err_o;

  // The walker itself: responder to both MMUs, master on the walker bus.
  modport master (
    input  dmmu_req_i, dmmu_addr_i, immu_req_i, immu_addr_i,
           wbm_ack_i, wbm_err_i, wbm_dat_i,
    output dmmu_ack_o, dmmu_data_o, immu_ack_o, immu_data_o,
           wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
           busy_o, bus_err_o
  );

  // The surroundings: the two MMU reload engines, the bus slave and the arbiter.
  modport slave (
    output dmmu_req_i, dmmu_addr_i, immu_req_i, immu_addr_i,
           wbm_ack_i, wbm_err_i, wbm_dat_i,
    input  dmmu_ack_o, dmmu_data_o, immu_ack_o, immu_data_o,
           wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
           busy_o, bus_err_o
  );
endinterface

// File: rtl/mor1kx_tlb_reload_walker_port.sv
// Services DMMU/IMMU page-table reads with single Wishbone classic read cycles,
// locking the bus to one MMU for the duration of its walk.
module mor1kx_tlb_reload_walker_port #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input logic clk,
  input logic rst_n,
  mor1kx_tlb_reload_walker_port_if.master port
);
  localparam int              W            = OPTION_OPERAND_WIDTH;
  localparam bit              TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0]     TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'hffff;
  localparam logic [W-1:0]    WORD_MASK    = {{(W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef enum logic {OWNER_DMMU, OWNER_IMMU} owner_t;

  state_t      state;
  owner_t      owner;
  logic        lock;
  logic        aborted;
  logic [15:0] tmo_cnt;

  logic [W-1:0] adr_q;
  logic [W-1:0] dmmu_data_q;
  logic [W-1:0] immu_data_q;
  logic         cyc_q;
  logic         dmmu_ack_q;
  logic         immu_ack_q;
  logic         busy_q;
  logic         bus_err_q;

  logic         owner_req;
  logic         sel_valid;
  owner_t       sel_owner;
  logic [W-1:0] sel_addr;
  logic         timeout_hit;
  logic         bus_done;
  logic         bus_fail;
  logic         discard;
  logic [W-1:0] rsp_data;

  assign owner_req = (owner == OWNER_IMMU) ? port.immu_req_i : port.dmmu_req_i;

  // A held lock keeps the second read of a walk with its owner; otherwise DMMU wins.
  always_comb begin
    sel_valid = 1'b1;
    sel_owner = owner;
    if (lock && owner_req)
      sel_owner = owner;
    else if (port.dmmu_req_i)
      sel_owner = OWNER_DMMU;
    else if (port.immu_req_i)
      sel_owner = OWNER_IMMU;
    else
      sel_valid = 1'b0;
  end

  assign sel_addr    = ((sel_owner == OWNER_IMMU) ? port.immu_addr_i : port.dmmu_addr_i) & WORD_MASK;
  assign timeout_hit = TIMEOUT_EN && (tmo_cnt == TIMEOUT_LAST);
  assign bus_done    = port.wbm_ack_i | port.wbm_err_i | timeout_hit;
  // Error and timeout both return zero data so the requester raises a pagefault.
  assign bus_fail    = port.wbm_err_i | ~port.wbm_ack_i;
  assign rsp_data    = bus_fail ? '0 : port.wbm_dat_i;
  assign discard     = aborted | ~owner_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWNER_DMMU;
      lock        <= 1'b0;
      aborted     <= 1'b0;
      tmo_cnt     <= '0;
      adr_q       <= '0;
      dmmu_data_q <= '0;
      immu_data_q <= '0;
      cyc_q       <= 1'b0;
      dmmu_ack_q  <= 1'b0;
      immu_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      dmmu_ack_q <= 1'b0;
      immu_ack_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state   <= BUS;
            owner   <= sel_owner;
            lock    <= 1'b1;
            aborted <= 1'b0;
            tmo_cnt <= '0;
            adr_q   <= sel_addr;
            cyc_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            lock   <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        BUS: begin
          if (!owner_req)
            aborted <= 1'b1;
          if (bus_done) begin
            cyc_q <= 1'b0;
            if (discard) begin
              state  <= IDLE;
              lock   <= 1'b0;
              busy_q <= 1'b0;
            end else begin
              state     <= RESP;
              bus_err_q <= bus_fail;
              if (owner == OWNER_IMMU) begin
                immu_ack_q  <= 1'b1;
                immu_data_q <= rsp_data;
              end else begin
                dmmu_ack_q  <= 1'b1;
                dmmu_data_q <= rsp_data;
              end
            end
          end else if (tmo_cnt != 16'hffff) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= lock;
        end
        default: begin
          state  <= IDLE;
          cyc_q  <= 1'b0;
          busy_q <= lock;
        end
      endcase
    end
  end

  assign port.wbm_adr_o   = adr_q;
  assign port.wbm_cyc_o   = cyc_q;
  assign port.wbm_stb_o   = cyc_q;
  assign port.wbm_we_o    = 1'b0;
  assign port.wbm_sel_o   = 4'hf;
  assign port.dmmu_ack_o  = dmmu_ack_q;
  assign port.dmmu_data_o = dmmu_data_q;
  assign port.immu_ack_o  = immu_ack_q;
  assign port.immu_data_o = immu_data_q;
  assign port.busy_o      = busy_q;
  assign port.bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mor1kx_tlb_reload_walker_port.sv
// Self-checking bench for the TLB reload walker port: directed walks plus randomized
// walks checked against a per-read behavioural model of arbitration and responses.
module tb_mor1kx_tlb_reload_walker_port;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] m_d_data, m_i_data;

  logic        o_got, o_held, o_d_ack, o_i_ack, o_berr, o_cyc_after;
  int          o_wait;
  logic [31:0] o_adr, o_d_data, o_i_data;

  mor1kx_tlb_reload_walker_port_if #(.OPTION_OPERAND_WIDTH(32)) wif();
  mor1kx_tlb_reload_walker_port_if #(.OPTION_OPERAND_WIDTH(32)) wif0();

  mor1kx_tlb_reload_walker_port #(.OPTION_OPERAND_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .port(wif.master));

  mor1kx_tlb_reload_walker_port #(.OPTION_OPERAND_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .port(wif0.master));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the bus slave for one read: waits for cyc, responds after lat cycles
  // (mode 0 ack, 1 err, 2 ack+err, 3 silent) and records what the walker showed.
  task automatic bus_serve(input int lat, input int mode, input logic [31:0] dat);
    int n = 0;
    while (wif.wbm_cyc_o !== 1'b1 && n < 20) begin tick(); n++; end
    o_got  = (wif.wbm_cyc_o === 1'b1) && (wif.wbm_stb_o === 1'b1);
    o_wait = n;
    o_adr  = wif.wbm_adr_o;
    o_held = 1'b1;
    for (int k = 0; k < lat; k++) begin
      tick();
      if (wif.wbm_cyc_o !== 1'b1) o_held = 1'b0;
    end
    if (mode != 3) begin
      wif.wbm_ack_i = (mode != 1);
      wif.wbm_err_i = (mode != 0);
      wif.wbm_dat_i = dat;
    end
    tick();
    wif.wbm_ack_i = 1'b0;
    wif.wbm_err_i = 1'b0;
    wif.wbm_dat_i = $urandom;
    o_d_ack = wif.dmmu_ack_o;  o_i_ack = wif.immu_ack_o;
    o_d_data = wif.dmmu_data_o; o_i_data = wif.immu_data_o;
    o_berr = wif.bus_err_o;    o_cyc_after = wif.wbm_cyc_o;
  endtask

  task automatic test_reset();
    n_tests++; if (wif.wbm_cyc_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cyc: got %b want 0", wif.wbm_cyc_o); end
    n_tests++; if (wif.wbm_stb_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stb: got %b want 0", wif.wbm_stb_o); end
    n_tests++; if (wif.wbm_we_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b want 0", wif.wbm_we_o); end
    n_tests++; if (wif.wbm_sel_o !== 4'hf) begin n_fail++; $display("[TB] FAIL reset_sel: got %h want f", wif.wbm_sel_o); end
    n_tests++; if (wif.wbm_adr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_adr: got %h want 0", wif.wbm_adr_o); end
    n_tests++; if (wif.dmmu_ack_o !== 1'b0 || wif.immu_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack: got %b%b want 00", wif.dmmu_ack_o, wif.immu_ack_o); end
    n_tests++; if (wif.dmmu_data_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ddata: got %h want 0", wif.dmmu_data_o); end
    n_tests++; if (wif.immu_data_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_idata: got %h want 0", wif.immu_data_o); end
    n_tests++; if (wif.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", wif.busy_o); end
    n_tests++; if (wif.bus_err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_berr: got %b want 0", wif.bus_err_o); end
    m_d_data = 32'h0;
    m_i_data = 32'h0;
  endtask

  task automatic test_dmmu_walk();
    logic [31:0] d2 = $urandom;
    wif.dmmu_addr_i = 32'h0001_2344;
    wif.dmmu_req_i  = 1'b1;
    bus_serve(0, 0, 32'h8000_2000);
    n_tests++; if (o_got !== 1'b1 || o_wait != 1) begin n_fail++; $display("[TB] FAIL walk1_start: got cyc %b after %0d want 1 after 1", o_got, o_wait); end
    n_tests++; if (o_adr !== 32'h0001_2344) begin n_fail++; $display("[TB] FAIL walk1_adr: got %h want 00012344", o_adr); end
    n_tests++; if (o_d_ack !== 1'b1 || o_i_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL walk1_ack: got d%b i%b want d1 i0", o_d_ack, o_i_ack); end
    n_tests++; if (o_d_data !== 32'h8000_2000) begin n_fail++; $display("[TB] FAIL walk1_data: got %h want 80002000", o_d_data); end
    n_tests++; if (o_cyc_after !== 1'b0 || o_berr !== 1'b0) begin n_fail++; $display("[TB] FAIL walk1_end: got cyc %b berr %b want 0 0", o_cyc_after, o_berr); end
    m_d_data = 32'h8000_2000;
    wif.dmmu_addr_i = 32'h8000_2010;
    bus_serve($urandom_range(0, 3), 0, d2);
    n_tests++; if (o_got !== 1'b1 || o_wait != 2) begin n_fail++; $display("[TB] FAIL walk2_start: got cyc %b after %0d want 1 after 2", o_got, o_wait); end
    n_tests++; if (o_adr !== 32'h8000_2010) begin n_fail++; $display("[TB] FAIL walk2_adr: got %h want 80002010", o_adr); end
    n_tests++; if (o_d_ack !== 1'b1 || o_d_data !== d2) begin n_fail++; $display("[TB] FAIL walk2_resp: got ack %b data %h want 1 %h", o_d_ack, o_d_data, d2); end
    m_d_data = d2;
    wif.dmmu_req_i = 1'b0;
    tick();
    n_tests++; if (wif.dmmu_ack_o !== 1'b0 || wif.busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL walk_tail: got ack %b busy %b want 0 1", wif.dmmu_ack_o, wif.busy_o); end
    tick();
    n_tests++; if (wif.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL walk_unlock: got busy %b want 0", wif.busy_o); end
  endtask

  task automatic test_arbitration();
    logic [31:0] da = $urandom, da2 = $urandom, ia = $urandom, ia2 = $urandom;
    logic [31:0] dd = $urandom, dd2 = $urandom, idat = $urandom | 32'h1;
    wif.dmmu_addr_i = da; wif.immu_addr_i = ia;
    wif.dmmu_req_i = 1'b1; wif.immu_req_i = 1'b1;
    bus_serve($urandom_range(0, 3), 0, dd);
    n_tests++; if (o_adr !== (da & ~32'h3) || o_d_ack !== 1'b1 || o_i_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL arb_first: got adr %h d%b i%b want %h d1 i0", o_adr, o_d_ack, o_i_ack, da & ~32'h3); end
    m_d_data = dd;
    wif.dmmu_addr_i = da2;
    bus_serve($urandom_range(0, 3), 0, dd2);
    n_tests++; if (o_wait != 2 || o_adr !== (da2 & ~32'h3) || o_d_ack !== 1'b1 || o_i_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL arb_second: got wait %0d adr %h d%b i%b want 2 %h d1 i0", o_wait, o_adr, o_d_ack, o_i_ack, da2 & ~32'h3); end
    m_d_data = dd2;
    wif.dmmu_req_i = 1'b0;
    bus_serve($urandom_range(0, 3), 0, idat);
    n_tests++; if (o_wait != 2 || o_adr !== (ia & ~32'h3) || o_i_ack !== 1'b1 || o_d_ack !== 1'b0 || o_i_data !== idat) begin n_fail++; $display("[TB] FAIL arb_immu: got wait %0d adr %h i%b d%b data %h want 2 %h i1 d0 %h", o_wait, o_adr, o_i_ack, o_d_ack, o_i_data, ia & ~32'h3, idat); end
    m_i_data = idat;
    wif.immu_req_i = 1'b0;
    tick(); tick();
    // IMMU walk in progress must keep the bus even when DMMU shows up between its reads
    wif.immu_addr_i = ia2;
    wif.immu_req_i = 1'b1;
    idat = $urandom | 32'h1;
    bus_serve(0, 0, idat);
    m_i_data = idat;
    wif.dmmu_addr_i = da; wif.dmmu_req_i = 1'b1;
    wif.immu_addr_i = ia;
    idat = $urandom | 32'h1;
    bus_serve($urandom_range(0, 3), 0, idat);
    n_tests++; if (o_adr !== (ia & ~32'h3) || o_i_ack !== 1'b1 || o_d_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_hold: got adr %h i%b d%b want %h i1 d0", o_adr, o_i_ack, o_d_ack, ia & ~32'h3); end
    m_i_data = idat;
    wif.immu_req_i = 1'b0;
    bus_serve(0, 0, dd);
    n_tests++; if (o_wait != 2 || o_adr !== (da & ~32'h3) || o_d_ack !== 1'b1 || o_i_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_handover: got wait %0d adr %h d%b i%b want 2 %h d1 i0", o_wait, o_adr, o_d_ack, o_i_ack, da & ~32'h3); end
    m_d_data = dd;
    wif.dmmu_req_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_abort();
    wif.dmmu_addr_i = $urandom;
    wif.dmmu_req_i  = 1'b1;
    tick();
    n_tests++; if (wif.wbm_cyc_o !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_start: got cyc %b want 1", wif.wbm_cyc_o); end
    wif.dmmu_req_i = 1'b0;
    tick(); tick();
    n_tests++; if (wif.wbm_cyc_o !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_completes: got cyc %b want 1", wif.wbm_cyc_o); end
    wif.wbm_ack_i = 1'b1;
    wif.wbm_dat_i = ~m_d_data;
    tick();
    wif.wbm_ack_i = 1'b0;
    n_tests++; if (wif.wbm_cyc_o !== 1'b0 || wif.dmmu_ack_o !== 1'b0 || wif.bus_err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_end: got cyc %b ack %b berr %b want 0 0 0", wif.wbm_cyc_o, wif.dmmu_ack_o, wif.bus_err_o); end
    n_tests++; if (wif.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_idle: got busy %b want 0", wif.busy_o); end
    n_tests++; if (wif.dmmu_data_o !== m_d_data) begin n_fail++; $display("[TB] FAIL abort_data: got %h want %h", wif.dmmu_data_o, m_d_data); end
    tick();
    n_tests++; if (wif.dmmu_ack_o !== 1'b0 || wif.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_quiet: got ack %b busy %b want 0 0", wif.dmmu_ack_o, wif.busy_o); end
  endtask

  task automatic test_bus_error();
    wif.dmmu_addr_i = $urandom;
    wif.dmmu_req_i  = 1'b1;
    bus_serve($urandom_range(0, 3), 1, $urandom | 32'h1);
    n_tests++; if (o_d_ack !== 1'b1 || o_d_data !== 32'h0 || o_berr !== 1'b1) begin n_fail++; $display("[TB] FAIL err_resp: got ack %b data %h berr %b want 1 0 1", o_d_ack, o_d_data, o_berr); end
    n_tests++; if (o_cyc_after !== 1'b0) begin n_fail++; $display("[TB] FAIL err_cyc: got %b want 0", o_cyc_after); end
    m_d_data = 32'h0;
    wif.dmmu_addr_i = $urandom;
    tick();
    n_tests++; if (wif.bus_err_o !== 1'b0 || wif.dmmu_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL err_pulse: got berr %b ack %b want 0 0", wif.bus_err_o, wif.dmmu_ack_o); end
    bus_serve(0, 2, $urandom | 32'h1);
    n_tests++; if (o_wait != 1 || o_d_ack !== 1'b1 || o_d_data !== 32'h0 || o_berr !== 1'b1) begin n_fail++; $display("[TB] FAIL err_with_ack: got wait %0d ack %b data %h berr %b want 1 1 0 1", o_wait, o_d_ack, o_d_data, o_berr); end
    wif.dmmu_req_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    logic [31:0] dat = $urandom | 32'h1;
    wif.immu_addr_i = $urandom;
    wif.immu_req_i  = 1'b1;
    bus_serve(3, 3, 32'h0);
    n_tests++; if (o_wait != 1 || o_held !== 1'b1) begin n_fail++; $display("[TB] FAIL tmo_hold: got wait %0d held %b want 1 1", o_wait, o_held); end
    n_tests++; if (o_cyc_after !== 1'b0 || o_i_ack !== 1'b1 || o_i_data !== 32'h0 || o_berr !== 1'b1 || o_d_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_resp: got cyc %b i%b data %h berr %b d%b want 0 1 0 1 0", o_cyc_after, o_i_ack, o_i_data, o_berr, o_d_ack); end
    m_i_data = 32'h0;
    wif.immu_addr_i = $urandom;
    bus_serve(3, 0, dat);
    n_tests++; if (o_i_ack !== 1'b1 || o_i_data !== dat || o_berr !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_last_ack: got ack %b data %h berr %b want 1 %h 0", o_i_ack, o_i_data, o_berr, dat); end
    m_i_data = dat;
    wif.immu_req_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] a = $urandom, dat = $urandom;
    int n = 0;
    wif.dmmu_addr_i = $urandom;
    wif.dmmu_req_i  = 1'b1;
    while (wif.wbm_cyc_o !== 1'b1 && n < 20) begin tick(); n++; end
    n_tests++; if (wif.wbm_cyc_o !== 1'b1) begin n_fail++; $display("[TB] FAIL arst_start: got cyc %b want 1", wif.wbm_cyc_o); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (wif.wbm_cyc_o !== 1'b0 || wif.wbm_stb_o !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_bus: got cyc %b stb %b want 0 0", wif.wbm_cyc_o, wif.wbm_stb_o); end
    n_tests++; if (wif.dmmu_ack_o !== 1'b0 || wif.immu_ack_o !== 1'b0 || wif.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_out: got d%b i%b busy %b want 0 0 0", wif.dmmu_ack_o, wif.immu_ack_o, wif.busy_o); end
    wif.dmmu_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_d_data = 32'h0;
    m_i_data = 32'h0;
    wif.dmmu_addr_i = a;
    wif.dmmu_req_i  = 1'b1;
    bus_serve($urandom_range(0, 3), 0, dat);
    n_tests++; if (o_wait != 1 || o_adr !== (a & ~32'h3) || o_d_ack !== 1'b1 || o_d_data !== dat) begin n_fail++; $display("[TB] FAIL arst_fresh: got wait %0d adr %h ack %b data %h want 1 %h 1 %h", o_wait, o_adr, o_d_ack, o_d_data, a & ~32'h3, dat); end
    m_d_data = dat;
    wif.dmmu_req_i = 1'b0;
    tick(); tick();
  endtask

  // Model: DMMU walks before IMMU when both arrive together; each walk keeps the bus
  // until its requester drops req; a failed read returns zero; the other side's data holds.
  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [1:0]  who = 2'($urandom_range(1, 3));
      int          nrd[2];
      logic [31:0] addr[2];
      bit          first = 1'b1;
      nrd[0] = $urandom_range(1, 2);
      nrd[1] = $urandom_range(1, 2);
      addr[0] = $urandom;
      addr[1] = $urandom;
      wif.dmmu_addr_i = addr[0]; wif.immu_addr_i = addr[1];
      wif.dmmu_req_i = who[0];   wif.immu_req_i = who[1];
      for (int side = 0; side < 2; side++) begin
        if (who[side]) begin
          for (int r = 0; r < nrd[side]; r++) begin
            int          lat  = $urandom_range(0, 3);
            int          mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            logic [31:0] dat  = $urandom;
            logic [31:0] exp_data = (mode == 0) ? dat : 32'h0;
            logic        own_ack, oth_ack;
            logic [31:0] own_data, oth_data, exp_oth;
            bus_serve(lat, mode, dat);
            own_ack  = side ? o_i_ack : o_d_ack;   oth_ack  = side ? o_d_ack : o_i_ack;
            own_data = side ? o_i_data : o_d_data; oth_data = side ? o_d_data : o_i_data;
            exp_oth  = side ? m_d_data : m_i_data;
            n_tests++; if (o_got !== 1'b1 || o_wait != (first ? 1 : 2)) begin n_fail++; $display("[TB] FAIL rnd_start it%0d: got cyc %b after %0d want 1 after %0d", it, o_got, o_wait, first ? 1 : 2); end
            n_tests++; if (o_adr !== (addr[side] & ~32'h3)) begin n_fail++; $display("[TB] FAIL rnd_adr it%0d: got %h want %h", it, o_adr, addr[side] & ~32'h3); end
            n_tests++; if (own_ack !== 1'b1 || oth_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_ack it%0d side%0d: got own %b other %b want 1 0", it, side, own_ack, oth_ack); end
            n_tests++; if (own_data !== exp_data) begin n_fail++; $display("[TB] FAIL rnd_data it%0d: got %h want %h", it, own_data, exp_data); end
            n_tests++; if (oth_data !== exp_oth) begin n_fail++; $display("[TB] FAIL rnd_hold it%0d: got %h want %h", it, oth_data, exp_oth); end
            n_tests++; if (o_berr !== (mode != 0) || o_cyc_after !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_end it%0d: got berr %b cyc %b want %b 0", it, o_berr, o_cyc_after, mode != 0); end
            if (side == 1) m_i_data = exp_data; else m_d_data = exp_data;
            first = 1'b0;
            if (r + 1 < nrd[side]) begin
              addr[side] = $urandom;
              if (side == 1) wif.immu_addr_i = addr[1]; else wif.dmmu_addr_i = addr[0];
            end else begin
              if (side == 1) wif.immu_req_i = 1'b0; else wif.dmmu_req_i = 1'b0;
            end
          end
        end
      end
      tick(); tick();
      n_tests++; if (wif.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_idle it%0d: got busy %b want 0", it, wif.busy_o); end
    end
  endtask

  task automatic test_timeout_disabled();
    logic        held = 1'b1, stray = 1'b0;
    logic [31:0] a = $urandom, dat = $urandom;
    wif0.immu_addr_i = a;
    wif0.immu_req_i  = 1'b1;
    tick();
    n_tests++; if (wif0.wbm_cyc_o !== 1'b1 || wif0.wbm_adr_o !== (a & ~32'h3)) begin n_fail++; $display("[TB] FAIL notmo_start: got cyc %b adr %h want 1 %h", wif0.wbm_cyc_o, wif0.wbm_adr_o, a & ~32'h3); end
    for (int k = 0; k < 300; k++) begin
      tick();
      if (wif0.wbm_cyc_o !== 1'b1) held = 1'b0;
      if (wif0.immu_ack_o !== 1'b0 || wif0.bus_err_o !== 1'b0) stray = 1'b1;
    end
    n_tests++; if (held !== 1'b1 || stray !== 1'b0) begin n_fail++; $display("[TB] FAIL notmo_hold: got held %b stray %b want 1 0", held, stray); end
    wif0.wbm_ack_i = 1'b1;
    wif0.wbm_dat_i = dat;
    tick();
    wif0.wbm_ack_i = 1'b0;
    n_tests++; if (wif0.immu_ack_o !== 1'b1 || wif0.immu_data_o !== dat || wif0.wbm_cyc_o !== 1'b0 || wif0.bus_err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL notmo_resp: got ack %b data %h cyc %b berr %b want 1 %h 0 0", wif0.immu_ack_o, wif0.immu_data_o, wif0.wbm_cyc_o, wif0.bus_err_o, dat); end
    wif0.immu_req_i = 1'b0;
    tick(); tick();
    n_tests++; if (wif0.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL notmo_idle: got busy %b want 0", wif0.busy_o); end
  endtask

  initial begin
    rst_n = 1'b0;
    wif.dmmu_req_i = 1'b0;  wif.dmmu_addr_i = '0;  wif.immu_req_i = 1'b0;  wif.immu_addr_i = '0;
    wif.wbm_ack_i = 1'b0;   wif.wbm_err_i = 1'b0;  wif.wbm_dat_i = $urandom;
    wif0.dmmu_req_i = 1'b0; wif0.dmmu_addr_i = '0; wif0.immu_req_i = 1'b0; wif0.immu_addr_i = '0;
    wif0.wbm_ack_i = 1'b0;  wif0.wbm_err_i = 1'b0; wif0.wbm_dat_i = $urandom;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick(); tick();
    test_dmmu_walk();
    test_arbitration();
    test_abort();
    test_bus_error();
    test_timeout();
    test_async_reset();
    test_random();
    test_timeout_disabled();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
